seg7_scan: RTL
==============

# seg7_scan

Parametrised, time-multiplexed hex display driver for DIGITS common-anode 7-segment digits.
- Captures a packed hex value and decimal points on a load strobe, then scans one digit per refresh slot.
- Applies new values only at frame boundaries, so a frame never shows a mix of old and new digits.
- Adds optional leading-zero blanking and an enable.
- Sits between the core's result/register outputs and the board display pins.

## Interface
Parameters:
- DIGITS, default 4: number of digits; legal range 1..8.
- DIV, default 50000: clock cycles per digit slot; must be at least 1.
- ANODE_LOW, default 1: 1 means `an` is active-low, 0 means active-high.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe; captures `value` and `dp` into the shadow register.
- value  in  4*DIGITS  hex nibbles; nibble k (bits 4k+3:4k) drives digit k; digit 0 is least significant.
- dp  in  DIGITS  decimal point per digit, 1 = lit.
- blank_lz  in  1  leading-zero blanking enable.
- en  in  1  display enable.
- seg  out  7  segments, active-low; seg[6]=a … seg[0]=g.
- seg_dp  out  1  decimal point, active-low.
- an  out  DIGITS  digit enables; polarity set by ANODE_LOW.
- frame  out  1  one-cycle pulse when the scan wraps to digit 0.

## Operation
- Registers:
  - shadow (value, dp) and pending flag.
  - active (value, dp).
  - prescaler `pre`, width max(1, clog2(DIV)).
  - digit index `idx`, width max(1, clog2(DIGITS)).
- Load path: when `load` is high, shadow <= {value, dp} and pending <= 1.
- Prescaler: counts 0..DIV-1. When `pre` == DIV-1, `pre` returns to 0 and `idx` advances.
- Digit index: `idx` wraps from DIGITS-1 to 0. On that wrap edge:
  - `frame` is 1 for the following cycle.
  - If pending, active <= shadow and pending <= 0.
- Coincident load and wrap: the wrap copies the shadow contents from before the edge. The new load sets pending and is applied at the next wrap.
- Glyphs, active-low, abcdefg:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
  - Blank = 1111111.
- Leading-zero blanking: with `blank_lz` = 1, digit k (k ≥ 1) is blanked when its active nibble and all more-significant nibbles are 0. Digit 0 is never blanked. `seg_dp` is not affected by blanking.
- Disable (`en` = 0):
  - `pre` and `idx` are held at 0; `frame` = 0.
  - `an` is all inactive, `seg` = 1111111, `seg_dp` = 1.
  - A pending shadow is copied to active on every disabled cycle.
  - When `en` returns to 1, scanning restarts at digit 0 with a full slot.

## Timing
- Outputs (`seg`, `seg_dp`, `an`, `frame`) are registered and lag `idx`/active by exactly one cycle.
- Each digit is driven for DIV consecutive cycles. A frame lasts DIGITS*DIV cycles.
- `frame` pulses once per frame, in the first output cycle of digit 0.
- Load-to-display latency: the first output cycle of the next frame, i.e. at most DIGITS*DIV+1 cycles after `load`.
- DIV = 1: `idx` advances every cycle. DIGITS = 1: `idx` stays 0, `frame` pulses every DIV cycles, and the load rules are unchanged.
- Reset state, asserted asynchronously, takes effect without waiting for a clock edge:
  - shadow = 0, active = 0, pending = 0, `pre` = 0, `idx` = 0.
  - `an` all inactive, `seg` = 1111111, `seg_dp` = 1, `frame` = 0.
- Reset mid-scan aborts the frame. After release, digit 0 is driven from the second edge, with active = 0.

## Structure
- Package `seg7_pkg`: the 16 glyph constants, the blank constant, and a 7-bit segment typedef.
- Sub-module `hex7_lut`: purely combinational, 4-bit nibble plus blank input to 7-bit glyph. One instance, fed by the nibble selected by `idx`.
- Top level holds the prescaler, index, shadow/active/pending registers, blanking evaluation and output registers.

## Test plan
Benches use DIGITS=4, DIV=4, ANODE_LOW=1.
1. Reset: assert `rst` between edges → `an`=1111, `seg`=1111111, `seg_dp`=1, `frame`=0 immediately; hold for 3 cycles with no change.
2. Scan order: load 16'h12AF, dp=0100 → next frame shows each digit for 4 cycles, with `frame` pulsing every 16 cycles:
   - `an`=1110, `seg`=0111000
   - `an`=1101, `seg`=0001000
   - `an`=1011, `seg`=0010010, `seg_dp`=0
   - `an`=0111, `seg`=1001111
3. Blanking: `blank_lz`=1.
   - 16'h0040 → digits 3 and 2 = 1111111, digit 1 = 1001100, digit 0 = 0000001.
   - 16'h0000 → only digit 0 = 0000001.
4. Frame-atomic update:
   - Load 16'h1111 at cycle 5 of a frame → the remainder of that frame still shows the old value; the next frame shows all 1001111.
   - Load 16'h2222 on a wrap edge → applied one frame later.
5. Enable: drop `en` mid-frame → all off on the next cycle and `frame` stays 0. Raise `en` → digit 0 for 4 full cycles, then digit 1.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared glyph definitions for the seg7_scan hex display driver.
// Segments are active-low and ordered abcdefg (bit 6 = a, bit 0 = g).
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t GLYPH_0 = 7'b0000001;
  localparam seg7_t GLYPH_1 = 7'b1001111;
  localparam seg7_t GLYPH_2 = 7'b0010010;
  localparam seg7_t GLYPH_3 = 7'b0000110;
  localparam seg7_t GLYPH_4 = 7'b1001100;
  localparam seg7_t GLYPH_5 = 7'b0100100;
  localparam seg7_t GLYPH_6 = 7'b0100000;
  localparam seg7_t GLYPH_7 = 7'b0001111;
  localparam seg7_t GLYPH_8 = 7'b0000000;
  localparam seg7_t GLYPH_9 = 7'b0000100;
  localparam seg7_t GLYPH_A = 7'b0001000;
  localparam seg7_t GLYPH_B = 7'b1100000;
  localparam seg7_t GLYPH_C = 7'b0110001;
  localparam seg7_t GLYPH_D = 7'b1000010;
  localparam seg7_t GLYPH_E = 7'b0110000;
  localparam seg7_t GLYPH_F = 7'b0111000;
  localparam seg7_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/hex7_lut.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
// The blank input overrides the nibble and turns every segment off.
module hex7_lut
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output seg7_t      glyph
);

  // Nibble decode with blank override
  always_comb begin
    glyph = SEG_BLANK;
    if (blank) begin
      glyph = SEG_BLANK;
    end else begin
      case (nibble)
        4'h0:    glyph = GLYPH_0;
        4'h1:    glyph = GLYPH_1;
        4'h2:    glyph = GLYPH_2;
        4'h3:    glyph = GLYPH_3;
        4'h4:    glyph = GLYPH_4;
        4'h5:    glyph = GLYPH_5;
        4'h6:    glyph = GLYPH_6;
        4'h7:    glyph = GLYPH_7;
        4'h8:    glyph = GLYPH_8;
        4'h9:    glyph = GLYPH_9;
        4'hA:    glyph = GLYPH_A;
        4'hB:    glyph = GLYPH_B;
        4'hC:    glyph = GLYPH_C;
        4'hD:    glyph = GLYPH_D;
        4'hE:    glyph = GLYPH_E;
        4'hF:    glyph = GLYPH_F;
        default: glyph = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed hex display driver: one digit per DIV-cycle slot, with
// new values swapped in only at frame boundaries so a frame is never mixed.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int DIV       = 50000,
  parameter bit ANODE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  input  logic                  en,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]     PRE_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF   = ANODE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [4*DIGITS-1:0] shadow_val_r;
  logic [DIGITS-1:0]   shadow_dp_r;
  logic                pending_r;
  logic [4*DIGITS-1:0] active_val_r;
  logic [DIGITS-1:0]   active_dp_r;
  logic [PW-1:0]       pre_r;
  logic [IW-1:0]       idx_r;
  logic                started_r;
  logic                wrapped_r;

  logic                run_s;
  logic                slot_end_s;
  logic                wrap_s;
  logic                apply_s;
  logic [3:0]          nib_s;
  logic                dp_s;
  logic                lz_hit_s;
  logic                blank_s;
  logic [DIGITS-1:0]   an_on_s;
  seg7_t               glyph_s;

  // Scan control: started_r keeps the first cycle after reset idle so
  // digit 0 is first driven from the second edge after release.
  always_comb begin
    run_s      = en && started_r;
    slot_end_s = (pre_r == PRE_LAST);
    wrap_s     = run_s && slot_end_s && (idx_r == IDX_LAST);
    apply_s    = pending_r && (wrap_s || !run_s);
    blank_s    = blank_lz && lz_hit_s;
  end

  // Digit select and leading-zero evaluation, walking from the top digit down
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    nib_s    = 4'h0;
    dp_s     = 1'b0;
    lz_hit_s = 1'b0;
    an_on_s  = {DIGITS{1'b0}};
    for (int k = DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero && (active_val_r[4*k +: 4] == 4'h0);
      if (idx_r == IW'(k)) begin
        nib_s      = active_val_r[4*k +: 4];
        dp_s       = active_dp_r[k];
        an_on_s[k] = 1'b1;
        lz_hit_s   = all_zero && (k != 0);
      end else begin
        an_on_s[k] = 1'b0;
      end
    end
  end

  hex7_lut u_lut (
    .nibble (nib_s),
    .blank  (blank_s),
    .glyph  (glyph_s)
  );

  // Prescaler and digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_r     <= {PW{1'b0}};
      idx_r     <= {IW{1'b0}};
      started_r <= 1'b0;
      wrapped_r <= 1'b0;
    end else begin
      started_r <= 1'b1;
      wrapped_r <= wrap_s;
      if (!run_s) begin
        pre_r <= {PW{1'b0}};
        idx_r <= {IW{1'b0}};
      end else if (slot_end_s) begin
        pre_r <= {PW{1'b0}};
        if (idx_r == IDX_LAST) begin
          idx_r <= {IW{1'b0}};
        end else begin
          idx_r <= idx_r + IW'(1);
        end
      end else begin
        pre_r <= pre_r + PW'(1);
      end
    end
  end

  // Shadow capture and frame-boundary transfer; a load on the wrap edge
  // stays pending because active takes the pre-edge shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_val_r <= {(4*DIGITS){1'b0}};
      shadow_dp_r  <= {DIGITS{1'b0}};
      pending_r    <= 1'b0;
      active_val_r <= {(4*DIGITS){1'b0}};
      active_dp_r  <= {DIGITS{1'b0}};
    end else begin
      if (load) begin
        shadow_val_r <= value;
        shadow_dp_r  <= dp;
        pending_r    <= 1'b1;
      end else if (apply_s) begin
        pending_r    <= 1'b0;
      end else begin
        pending_r    <= pending_r;
      end
      if (apply_s) begin
        active_val_r <= shadow_val_r;
        active_dp_r  <= shadow_dp_r;
      end else begin
        active_val_r <= active_val_r;
        active_dp_r  <= active_dp_r;
      end
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg    <= SEG_BLANK;
      seg_dp <= 1'b1;
      an     <= AN_OFF;
      frame  <= 1'b0;
    end else if (!run_s) begin
      seg    <= SEG_BLANK;
      seg_dp <= 1'b1;
      an     <= AN_OFF;
      frame  <= 1'b0;
    end else begin
      seg    <= glyph_s;
      seg_dp <= ~dp_s;
      an     <= ANODE_LOW ? ~an_on_s : an_on_s;
      frame  <= wrapped_r;
    end
  end

endmodule
